// File: rtl/vga_tile_renderer.sv
// ---------------------------------------------------------------------------
// vga_tile_renderer
//
// Pixel stage that sits directly behind the VGA timer. The screen is a
// 40x30 grid of 16x16 tiles on 640x480. For every pixel the block looks up
// the glyph code of the tile in screen memory and then the 12-bit colour of
// that pixel inside the glyph in bitmap memory. Both memories are external
// and have a synchronous read with one clock of latency. Sync signals travel
// through the same number of registers as the pixel data, so the pins see
// RGB, hsync and vsync exactly aligned, four clocks after the timer.
//
// Ports
//   clk            system clock, everything is clocked on the rising edge
//   reset          asynchronous, active-high
//   x, y           pixel column / row from the timer
//   hsync_in       timer horizontal sync
//   vsync_in       timer vertical sync
//   activevideo_in timer visible-region flag
//   smem_addr      screen memory address, row*40+col (registered)
//   smem_char      screen memory data: MSB = blink attribute, rest = glyph
//   bmem_addr      bitmap memory address {glyph, y[3:0], x[3:0]}
//   bmem_color     bitmap memory data {R,G,B}
//   red/green/blue pixel colour to the pins (registered)
//   hsync, vsync   delayed syncs to the pins (registered)
// ---------------------------------------------------------------------------
module vga_tile_renderer #(
    parameter int   CHARBITS  = 5,
    parameter int   SMEM_AW   = 11,
    parameter int   BLINK_BIT = 5,
    parameter logic SYNC_IDLE = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  activevideo_in,
    output logic [SMEM_AW-1:0]    smem_addr,
    input  logic [CHARBITS-1:0]   smem_char,
    output logic [CHARBITS+6:0]   bmem_addr,
    input  logic [11:0]           bmem_color,
    output logic [3:0]            red,
    output logic [3:0]            green,
    output logic [3:0]            blue,
    output logic                  hsync,
    output logic                  vsync
);

    // -----------------------------------------------------------------------
    // Tile index arithmetic
    // -----------------------------------------------------------------------
    logic [4:0]  tileRow;
    logic [5:0]  tileCol;
    logic [10:0] rowTimes32;
    logic [10:0] rowTimes8;
    logic [10:0] tileIndex;
    logic        unusedBits;

    assign tileRow    = y[8:4];
    assign tileCol    = x[9:4];
    assign unusedBits = y[9];

    // row*40 is built as row*32 + row*8 so no multiplier is needed; the
    // largest index is 29*40+39 = 1199, which fits 11 bits without wrapping.
    always_comb begin
        rowTimes32 = {1'b0, tileRow, 5'b00000};
        rowTimes8  = {3'b000, tileRow, 3'b000};
        tileIndex  = rowTimes32 + rowTimes8 + {5'b00000, tileCol};
    end

    // -----------------------------------------------------------------------
    // Pipeline registers
    // -----------------------------------------------------------------------
    // Stage 1: screen memory address plus the in-tile pixel position and
    // timer flags that have to follow the data through the memories.
    logic [SMEM_AW-1:0] smemAddr_q, smemAddr_d;
    logic [3:0]         s1XLo_q, s1XLo_d;
    logic [3:0]         s1YLo_q, s1YLo_d;
    logic               s1Hs_q, s1Hs_d;
    logic               s1Vs_q, s1Vs_d;
    logic               s1Act_q, s1Act_d;

    // Stage 2: fields lined up with smem_char, which forms bmem_addr.
    logic [3:0]         s2XLo_q, s2XLo_d;
    logic [3:0]         s2YLo_q, s2YLo_d;
    logic               s2Hs_q, s2Hs_d;
    logic               s2Vs_q, s2Vs_d;
    logic               s2Act_q, s2Act_d;

    // Stage 3: fields lined up with bmem_color, plus the blink decision that
    // had to be taken while smem_char was still on the bus.
    logic               s3Hs_q, s3Hs_d;
    logic               s3Vs_q, s3Vs_d;
    logic               s3Act_q, s3Act_d;
    logic               s3Blink_q, s3Blink_d;

    // Stage 4: the pin registers.
    logic [11:0]        rgb_q, rgb_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;

    // Frame counter for the blink attribute.
    logic [5:0]         frameCnt_q, frameCnt_d;
    logic               vsyncPrev_q, vsyncPrev_d;
    logic               vsyncStart;

    // -----------------------------------------------------------------------
    // Next-state logic for the pipeline
    // -----------------------------------------------------------------------
    // The screen memory address only moves while the timer is inside the
    // visible area; during blanking x/y run past the grid and would point
    // outside screen memory, so the last valid address is held instead.
    always_comb begin
        smemAddr_d = smemAddr_q;
        if (activevideo_in) begin
            smemAddr_d = SMEM_AW'(tileIndex);
        end

        s1XLo_d = x[3:0];
        s1YLo_d = y[3:0];
        s1Hs_d  = hsync_in;
        s1Vs_d  = vsync_in;
        s1Act_d = activevideo_in;

        s2XLo_d = s1XLo_q;
        s2YLo_d = s1YLo_q;
        s2Hs_d  = s1Hs_q;
        s2Vs_d  = s1Vs_q;
        s2Act_d = s1Act_q;

        s3Hs_d    = s2Hs_q;
        s3Vs_d    = s2Vs_q;
        s3Act_d   = s2Act_q;
        s3Blink_d = smem_char[CHARBITS-1] & frameCnt_q[BLINK_BIT];

        hsync_d = s3Hs_q;
        vsync_d = s3Vs_q;
        rgb_d   = 12'h000;
        if (s3Act_q && !s3Blink_q) begin
            rgb_d = bmem_color;
        end
    end

    // The glyph index and the in-tile position address one pixel of the
    // glyph bitmap; the read result arrives one clock later with stage 3.
    assign bmem_addr = {smem_char[CHARBITS-2:0], s2YLo_q, s2XLo_q};

    // -----------------------------------------------------------------------
    // Frame counter
    // -----------------------------------------------------------------------
    // Counting only the idle-to-active transition of vsync gives exactly one
    // step per sync pulse regardless of how many clocks the pulse lasts.
    always_comb begin
        vsyncPrev_d = vsync_in;
        vsyncStart  = (vsyncPrev_q == SYNC_IDLE) && (vsync_in == ~SYNC_IDLE);
        frameCnt_d  = frameCnt_q;
        if (vsyncStart) begin
            frameCnt_d = frameCnt_q + 6'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // The sync copies inside the pipe reset to the idle level rather than 0,
    // so releasing reset does not push a false sync pulse out to the monitor
    // while the pipe refills.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            smemAddr_q  <= '0;
            s1XLo_q     <= 4'h0;
            s1YLo_q     <= 4'h0;
            s1Hs_q      <= SYNC_IDLE;
            s1Vs_q      <= SYNC_IDLE;
            s1Act_q     <= 1'b0;
            s2XLo_q     <= 4'h0;
            s2YLo_q     <= 4'h0;
            s2Hs_q      <= SYNC_IDLE;
            s2Vs_q      <= SYNC_IDLE;
            s2Act_q     <= 1'b0;
            s3Hs_q      <= SYNC_IDLE;
            s3Vs_q      <= SYNC_IDLE;
            s3Act_q     <= 1'b0;
            s3Blink_q   <= 1'b0;
            rgb_q       <= 12'h000;
            hsync_q     <= SYNC_IDLE;
            vsync_q     <= SYNC_IDLE;
            frameCnt_q  <= 6'd0;
            vsyncPrev_q <= SYNC_IDLE;
        end else begin
            smemAddr_q  <= smemAddr_d;
            s1XLo_q     <= s1XLo_d;
            s1YLo_q     <= s1YLo_d;
            s1Hs_q      <= s1Hs_d;
            s1Vs_q      <= s1Vs_d;
            s1Act_q     <= s1Act_d;
            s2XLo_q     <= s2XLo_d;
            s2YLo_q     <= s2YLo_d;
            s2Hs_q      <= s2Hs_d;
            s2Vs_q      <= s2Vs_d;
            s2Act_q     <= s2Act_d;
            s3Hs_q      <= s3Hs_d;
            s3Vs_q      <= s3Vs_d;
            s3Act_q     <= s3Act_d;
            s3Blink_q   <= s3Blink_d;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            frameCnt_q  <= frameCnt_d;
            vsyncPrev_q <= vsyncPrev_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign smem_addr = smemAddr_q;
    assign red       = rgb_q[11:8];
    assign green     = rgb_q[7:4];
    assign blue      = rgb_q[3:0];
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;

endmodule

// File: tb/tb_vga_tile_renderer.sv
// ---------------------------------------------------------------------------
// tb_vga_tile_renderer
//
// Directed bench for vga_tile_renderer with behavioural screen and bitmap
// memories. Screen memory holds addr%16 (no blink) except for a few
// hand-placed glyphs; bitmap memory holds addr ^ 12'hA5A except for two
// hand-placed red pixels. Expected values are worked out by hand for the
// vector table and by a reference pixel model for the timer sweep.
// ---------------------------------------------------------------------------
module tb_vga_tile_renderer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  x = 10'd0;
    logic [9:0]  y = 10'd0;
    logic        hsyncIn = 1'b1;
    logic        vsyncIn = 1'b1;
    logic        activeIn = 1'b0;
    logic [10:0] smemAddr;
    logic [4:0]  smemChar;
    logic [11:0] bmemAddr;
    logic [11:0] bmemColor;
    logic [3:0]  red, green, blue;
    logic        hsync, vsync;

    int checks = 0;
    int errors = 0;

    logic [4:0]  smemArr [0:2047];
    logic [11:0] bmemArr [0:4095];

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        act;
        logic [10:0] expAddr;
        logic [11:0] expBmem;
        logic [11:0] expRgb;
        logic        expHs;
        logic        expVs;
    } vec_t;

    vec_t vecs [0:5];

    localparam int SB_CYCLES = 40 * 800;

    // reference model state for the timer sweep
    logic [9:0]  hX [0:7];
    logic [9:0]  hY [0:7];
    logic        hHs [0:7];
    logic        hVs [0:7];
    logic        hAct [0:7];
    logic [5:0]  frameHist [0:7];
    logic [5:0]  modFrame;
    logic        modVsPrev;
    int          sbH, sbV, tIdx, j;
    logic [4:0]  ch;
    logic [11:0] expRgb;
    logic        fb;

    always #5 clk = ~clk;

    vga_tile_renderer dut (
        .clk            (clk),
        .reset          (reset),
        .x              (x),
        .y              (y),
        .hsync_in       (hsyncIn),
        .vsync_in       (vsyncIn),
        .activevideo_in (activeIn),
        .smem_addr      (smemAddr),
        .smem_char      (smemChar),
        .bmem_addr      (bmemAddr),
        .bmem_color     (bmemColor),
        .red            (red),
        .green          (green),
        .blue           (blue),
        .hsync          (hsync),
        .vsync          (vsync)
    );

    // synchronous-read memories, one clock of latency each
    always @(posedge clk) begin
        smemChar  <= smemArr[smemAddr];
        bmemColor <= bmemArr[bmemAddr];
    end

    task applyStimulus(input logic [9:0] xv, input logic [9:0] yv,
                       input logic hs, input logic vs, input logic act);
        x        = xv;
        y        = yv;
        hsyncIn  = hs;
        vsyncIn  = vs;
        activeIn = act;
    endtask

    task checkOutput(input string name, input logic [31:0] actual,
                     input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // n rising edges, then settle on the following falling edge
    task stepClk(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task vsyncPulse(input int width);
        vsyncIn = 1'b0;
        stepClk(width);
        vsyncIn = 1'b1;
        stepClk(1);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) smemArr[i] = 5'(i % 16);
        for (int i = 0; i < 4096; i++) bmemArr[i] = 12'(i) ^ 12'hA5A;
        smemArr[41]      = 5'h05;
        smemArr[82]      = 5'h15;
        bmemArr[12'h501] = 12'hF00;
        bmemArr[12'h500] = 12'hF00;

        //            x        y        hs    vs    act   addr      bmem      rgb       hs    vs
        vecs[0] = '{10'd17,  10'd16,  1'b1, 1'b1, 1'b1, 11'd41,   12'h501, 12'hF00, 1'b1, 1'b1};
        vecs[1] = '{10'd639, 10'd479, 1'b1, 1'b1, 1'b1, 11'd1199, 12'hFFF, 12'h5A5, 1'b1, 1'b1};
        vecs[2] = '{10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 11'd0,    12'h000, 12'hA5A, 1'b1, 1'b1};
        vecs[3] = '{10'd100, 10'd200, 1'b1, 1'b1, 1'b1, 11'd486,  12'h684, 12'hCDE, 1'b1, 1'b1};
        vecs[4] = '{10'd300, 10'd100, 1'b0, 1'b1, 1'b0, 11'd486,  12'h64C, 12'h000, 1'b0, 1'b1};
        vecs[5] = '{10'd320, 10'd240, 1'b0, 1'b0, 1'b1, 11'd620,  12'hC00, 12'h65A, 1'b0, 1'b0};

        // reset state
        applyStimulus(10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
        stepClk(2);
        checkOutput("resetAddr",  32'(smemAddr), 32'd0);
        checkOutput("resetRgb",   32'({red, green, blue}), 32'h000);
        checkOutput("resetHsync", 32'(hsync), 32'd1);
        checkOutput("resetVsync", 32'(vsync), 32'd1);
        reset = 1'b0;

        // vector table: each input held long enough to fill the pipe
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].x, vecs[i].y, vecs[i].hs, vecs[i].vs, vecs[i].act);
            stepClk(1);
            checkOutput($sformatf("vec%0d addr", i), 32'(smemAddr), 32'(vecs[i].expAddr));
            stepClk(3);
            checkOutput($sformatf("vec%0d bmem", i), 32'(bmemAddr), 32'(vecs[i].expBmem));
            checkOutput($sformatf("vec%0d rgb", i), 32'({red, green, blue}), 32'(vecs[i].expRgb));
            checkOutput($sformatf("vec%0d hsync", i), 32'(hsync), 32'(vecs[i].expHs));
            checkOutput($sformatf("vec%0d vsync", i), 32'(vsync), 32'(vecs[i].expVs));
        end

        // asynchronous reset mid-stream, checked before any clock edge
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncRgb",   32'({red, green, blue}), 32'h000);
        checkOutput("asyncHsync", 32'(hsync), 32'd1);
        checkOutput("asyncVsync", 32'(vsync), 32'd1);
        checkOutput("asyncAddr",  32'(smemAddr), 32'd0);
        applyStimulus(10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);

        // single-cycle active pixel with hsync pulse right after reset release
        reset = 1'b0;
        applyStimulus(10'd17, 10'd16, 1'b0, 1'b1, 1'b1);
        for (int e = 1; e <= 6; e++) begin
            stepClk(1);
            if (e == 1) begin
                checkOutput("latAddr", 32'(smemAddr), 32'd41);
                applyStimulus(10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
            end
            if (e == 2) checkOutput("latBmem", 32'(bmemAddr), 32'h501);
            checkOutput($sformatf("latHsync e%0d", e), 32'(hsync), (e == 4) ? 32'd0 : 32'd1);
            checkOutput($sformatf("latRgb e%0d", e), 32'({red, green, blue}),
                        (e == 4) ? 32'hF00 : 32'h000);
        end

        // blink attribute against the frame counter
        applyStimulus(10'd32, 10'd32, 1'b1, 1'b1, 1'b1);
        stepClk(4);
        checkOutput("blinkFrame0", 32'({red, green, blue}), 32'hF00);
        for (int p = 0; p < 30; p++) vsyncPulse(1);
        vsyncPulse(3);
        stepClk(5);
        checkOutput("blinkFrame31", 32'({red, green, blue}), 32'hF00);
        vsyncPulse(1);
        stepClk(5);
        checkOutput("blinkFrame32", 32'({red, green, blue}), 32'h000);
        for (int p = 0; p < 32; p++) vsyncPulse(1);
        stepClk(5);
        checkOutput("blinkWrap", 32'({red, green, blue}), 32'hF00);
        for (int p = 0; p < 32; p++) vsyncPulse(1);
        stepClk(5);
        checkOutput("blinkAgain", 32'({red, green, blue}), 32'h000);
        reset = 1'b1;
        stepClk(1);
        reset = 1'b0;
        stepClk(4);
        checkOutput("frameRestart", 32'({red, green, blue}), 32'hF00);

        // free-running 640x480 timer across the bottom rows and vsync
        modFrame  = 6'd0;
        modVsPrev = 1'b1;
        for (int k = 0; k < SB_CYCLES; k++) begin
            sbH = k % 800;
            sbV = 470 + k / 800;
            applyStimulus(10'(sbH), 10'(sbV), !(sbH >= 656 && sbH < 752),
                          !(sbV >= 490 && sbV < 492), (sbH < 640) && (sbV < 480));
            hX[k % 8]   = x;
            hY[k % 8]   = y;
            hHs[k % 8]  = hsyncIn;
            hVs[k % 8]  = vsyncIn;
            hAct[k % 8] = activeIn;
            @(posedge clk);
            frameHist[k % 8] = modFrame;
            if (modVsPrev && !vsyncIn) modFrame = modFrame + 6'd1;
            modVsPrev = vsyncIn;
            @(negedge clk);
            if (k >= 3) begin
                j  = (k - 3) % 8;
                fb = frameHist[(k - 1) % 8][5];
                expRgb = 12'h000;
                if (hAct[j]) begin
                    tIdx   = (int'(hY[j]) / 16) * 40 + int'(hX[j]) / 16;
                    ch     = smemArr[tIdx];
                    expRgb = (ch[4] && fb) ? 12'h000
                                           : bmemArr[{ch[3:0], hY[j][3:0], hX[j][3:0]}];
                end
                checkOutput($sformatf("sweep k%0d", k),
                            32'({red, green, blue, hsync, vsync}),
                            32'({expRgb, hHs[j], hVs[j]}));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
